writeback_arbiter: RTL and testbench
====================================

// Module: writeback_arbiter
// PURPOSE
//  Write-side counterpart of the instruction arbiter: the arbiter reads memory and splits work into
//  two pipeline lanes; this block collects completed results from both lanes and writes them
//  back through the memory write port (w_adrs/data_in/w_en). Each lane has a small result FIFO,
//  and a round-robin grant picks one head entry per cycle and drives a single registered write.
// PARAMETERS
//  DATA_W   32  result data width, matches memory data_in
//  ADDR_W   11  memory word-address width, matches w_adrs
//  DEPTH    4   entries per lane FIFO; power of two, >=2
// PORTS
//  clk          in   1            system clock, all logic on rising edge
//  reset        in   1            asynchronous, active-high reset
//  l1_valid     in   1            lane 1 result valid
//  l1_ready     out  1            lane 1 FIFO can accept (not full)
//  l1_adrs      in   ADDR_W       lane 1 destination address
//  l1_data      in   DATA_W       lane 1 result data
//  l2_valid     in   1            lane 2 result valid
//  l2_ready     out  1            lane 2 FIFO can accept
//  l2_adrs      in   ADDR_W       lane 2 destination address
//  l2_data      in   DATA_W       lane 2 result data
//  w_en         out  1            memory write strobe, one cycle per write
//  w_adrs       out  ADDR_W       memory write address
//  data_in      out  DATA_W       memory write data
//  l1_count     out  clog2(DEPTH)+1  lane 1 FIFO occupancy
//  l2_count     out  clog2(DEPTH)+1  lane 2 FIFO occupancy
//  busy         out  1            any FIFO non-empty or w_en high
// BEHAVIOUR
//  - Reset (async, while high): w_en=0, w_adrs=0, data_in=0, counts=0, FIFO pointers=0,
//    last_grant=LANE2 (so lane 1 wins first tie), l1_ready=l2_ready=0. Asserting reset mid-operation
//    discards all buffered entries; no partial write issued after release.
//  - Push: entry written when lx_valid && lx_ready at clk edge. lx_ready = !reset && count<DEPTH.
//    No push-through-full: a full FIFO deasserts ready even if popped in the same cycle.
//  - Grant (comb., on current state): neither non-empty -> none; one non-empty -> that lane;
//    both -> lane != last_grant. Granted head is popped and registered to w_adrs/data_in with
//    w_en=1 next edge; last_grant updates only on a grant. No grant -> w_en=0, w_adrs/data_in hold.
//  - Latency: entry pushed into empty FIFO at edge N (other lane empty) -> w_en high after edge N+1.
//  - Throughput: exactly one write per cycle max; both lanes full -> strict alternation L1,L2,L1...
//  - Simultaneous push+pop on same lane: count unchanged; pointers wrap modulo DEPTH.
//  - Same address from both lanes: no merging; written in grant order, later write wins in memory.
//  - Ordering within a lane strictly FIFO; no ordering guarantee across lanes except by grant.
//  - State: grant FSM {LAST_L1, LAST_L2}; transitions only on grant to the other lane.
// CONFIGURATION
//  WB_FIXED_PRIO_EN: when defined, grant is fixed priority: lane 1 whenever non-empty, else lane 2;
//  last_grant register removed. Undefined (default): round-robin as above. Lane 2 may starve
//  under fixed priority; this is accepted.
// TESTING
//  1 Reset: hold reset 2 cycles -> w_en=0, w_adrs=0, counts=0, readys=0; release -> readys=1.
//  2 Single write: push l1 (adrs=0x005,data=0xDEADBEEF) at edge N -> w_en=1, w_adrs=0x005,
//    data_in=0xDEADBEEF after edge N+1 for one cycle, busy drops next cycle.
//  3 Tie: push l1 A=0x010 and l2 A=0x020 same edge after reset -> writes 0x010 then 0x020
//    on consecutive cycles; with WB_FIXED_PRIO_EN and streaming l1, l2 waits until l1 empties.
//  4 Full: push 5 entries to l1 with downstream drained by l2 traffic -> l1_ready=0 at count=4,
//    5th accepted only after a pop; all 5 written in push order.
//  5 Both full, both streaming -> w_en high every cycle, lanes strictly alternate 1,2,1,2.
//  6 Reset mid-stream with 3 entries queued -> no w_en after reset release, counts=0.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Collects results from two pipeline lanes in small FIFOs and writes them back one per cycle.
// Define WB_FIXED_PRIO_EN for fixed lane-1 priority instead of round-robin.
module writeback_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     l1_valid,
    output logic                     l1_ready,
    input  logic [ADDR_W-1:0]        l1_adrs,
    input  logic [DATA_W-1:0]        l1_data,
    input  logic                     l2_valid,
    output logic                     l2_ready,
    input  logic [ADDR_W-1:0]        l2_adrs,
    input  logic [DATA_W-1:0]        l2_data,
    output logic                     w_en,
    output logic [ADDR_W-1:0]        w_adrs,
    output logic [DATA_W-1:0]        data_in,
    output logic [$clog2(DEPTH):0]   l1_count,
    output logic [$clog2(DEPTH):0]   l2_count,
    output logic                     busy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = ADDR_W + DATA_W;

    logic [EW-1:0] fifo [2][DEPTH];
    logic [PW-1:0] wr_ptr [2];
    logic [PW-1:0] rd_ptr [2];
    logic [CW-1:0] count [2];
    logic [EW-1:0] in_entry [2];
    logic [EW-1:0] head [2];
    logic [1:0]    in_valid;
    logic [1:0]    ready;
    logic [1:0]    push;
    logic [1:0]    nonempty;
    logic [1:0]    grant;

    assign in_valid    = {l2_valid, l1_valid};
    assign in_entry[0] = {l1_adrs, l1_data};
    assign in_entry[1] = {l2_adrs, l2_data};
    assign l1_ready    = ready[0];
    assign l2_ready    = ready[1];
    assign l1_count    = count[0];
    assign l2_count    = count[1];
    assign busy        = (|nonempty) | w_en;

    // Ready depends only on occupancy, so a full lane never pushes through a same-cycle pop.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready[i]    = !reset && (count[i] < CW'(DEPTH));
            push[i]     = in_valid[i] && ready[i];
            nonempty[i] = (count[i] != '0);
            head[i]     = fifo[i][rd_ptr[i]];
        end
    end

`ifdef WB_FIXED_PRIO_EN
    // Lane 1 always wins when it has data; lane 2 may starve.
    always_comb begin
        grant = 2'b00;
        if (nonempty[0])      grant = 2'b01;
        else if (nonempty[1]) grant = 2'b10;
    end
`else
    typedef enum logic {LAST_L1, LAST_L2} state_t;
    state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LAST_L2;
        else       state_q <= state_d;
    end

    // Round-robin: on a tie the lane not granted last time wins.
    always_comb begin
        grant   = 2'b00;
        state_d = state_q;
        if (nonempty[0] && nonempty[1])
            grant = (state_q == LAST_L2) ? 2'b01 : 2'b10;
        else if (nonempty[0])
            grant = 2'b01;
        else if (nonempty[1])
            grant = 2'b10;
        if (grant[0])      state_d = LAST_L1;
        else if (grant[1]) state_d = LAST_L2;
    end
`endif

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            if (push[i]) fifo[i][wr_ptr[i]] <= in_entry[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i])  wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (grant[i]) rd_ptr[i] <= rd_ptr[i] + PW'(1);
                count[i] <= count[i] + CW'(push[i]) - CW'(grant[i]);
            end
        end
    end

    // Single registered write port; address and data hold when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_en    <= 1'b0;
            w_adrs  <= '0;
            data_in <= '0;
        end else begin
            w_en <= |grant;
            if (grant[0]) begin
                w_adrs  <= head[0][EW-1 -: ADDR_W];
                data_in <= head[0][DATA_W-1:0];
            end else if (grant[1]) begin
                w_adrs  <= head[1][EW-1 -: ADDR_W];
                data_in <= head[1][DATA_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a queue-based model.
module tb_writeback_arbiter;
    localparam int DEPTH = 4;

    logic        clk, reset;
    logic        l1_valid, l1_ready, l2_valid, l2_ready;
    logic [10:0] l1_adrs, l2_adrs, w_adrs;
    logic [31:0] l1_data, l2_data, data_in;
    logic        w_en, busy;
    logic [2:0]  l1_count, l2_count;

    writeback_arbiter #(.DATA_W(32), .ADDR_W(11), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_adrs(l1_adrs), .l1_data(l1_data),
        .l2_valid(l2_valid), .l2_ready(l2_ready), .l2_adrs(l2_adrs), .l2_data(l2_data),
        .w_en(w_en), .w_adrs(w_adrs), .data_in(data_in),
        .l1_count(l1_count), .l2_count(l2_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [10:0] adrs; logic [31:0] data; } ent_t;
    typedef struct {
        logic v1; logic [10:0] a1; logic [31:0] d1;
        logic v2; logic [10:0] a2; logic [31:0] d2;
        logic wen; logic [10:0] wa; logic [31:0] wd;
        logic [2:0] c1, c2; logic bsy;
    } vec_t;

    int   tests = 0, fails = 0;
    ent_t q1[$], q2[$];
    bit   m_last2;
    logic m_wen;
    logic [10:0] m_adrs;
    logic [31:0] m_data;
    int   wen_run, max_c1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q1.delete(); q2.delete();
        m_last2 = 1'b1; m_wen = 1'b0; m_adrs = '0; m_data = '0;
    endtask

    // One clock: drive inputs, predict from the model, check after the edge. Called at negedge.
    task automatic step(input logic v1, input logic [10:0] a1, input logic [31:0] d1,
                        input logic v2, input logic [10:0] a2, input logic [31:0] d2);
        int   g;
        bit   p1, p2;
        ent_t e;
        l1_valid = v1; l1_adrs = a1; l1_data = d1;
        l2_valid = v2; l2_adrs = a2; l2_data = d2;
        #1;
        chk("l1_ready", 64'(l1_ready), 64'(q1.size() < DEPTH));
        chk("l2_ready", 64'(l2_ready), 64'(q2.size() < DEPTH));
        p1 = v1 && (q1.size() < DEPTH);
        p2 = v2 && (q2.size() < DEPTH);
        g = 0;
`ifdef WB_FIXED_PRIO_EN
        if (q1.size() > 0)      g = 1;
        else if (q2.size() > 0) g = 2;
`else
        if (q1.size() > 0 && q2.size() > 0) g = m_last2 ? 1 : 2;
        else if (q1.size() > 0)             g = 1;
        else if (q2.size() > 0)             g = 2;
`endif
        m_wen = (g != 0);
        if (g == 1) begin e = q1.pop_front(); m_adrs = e.adrs; m_data = e.data; m_last2 = 1'b0; end
        if (g == 2) begin e = q2.pop_front(); m_adrs = e.adrs; m_data = e.data; m_last2 = 1'b1; end
        if (p1) q1.push_back({a1, d1});
        if (p2) q2.push_back({a2, d2});
        @(posedge clk); #1;
        chk("w_en", 64'(w_en), 64'(m_wen));
        chk("w_adrs", 64'(w_adrs), 64'(m_adrs));
        chk("data_in", 64'(data_in), 64'(m_data));
        chk("l1_count", 64'(l1_count), 64'(q1.size()));
        chk("l2_count", 64'(l2_count), 64'(q2.size()));
        chk("busy", 64'(busy), 64'((q1.size() + q2.size() > 0) || m_wen));
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 11'h0, 32'h0, 1'b0, 11'h0, 32'h0);
    endtask

    task automatic do_reset();
        l1_valid = 1'b0; l2_valid = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_w_en", 64'(w_en), 64'(0));
        chk("rst_w_adrs", 64'(w_adrs), 64'(0));
        chk("rst_counts", 64'({l1_count, l2_count}), 64'(0));
        chk("rst_readys", 64'({l1_ready, l2_ready}), 64'(0));
        reset = 1'b0;
        #1;
        chk("rel_readys", 64'({l1_ready, l2_ready}), 64'(2'b11));
    endtask

    vec_t vt [9];

    initial begin
        reset = 1'b1;
        l1_valid = 1'b0; l1_adrs = '0; l1_data = '0;
        l2_valid = 1'b0; l2_adrs = '0; l2_data = '0;
        model_reset();

        vt[0] = '{1'b1, 11'h010, 32'h11111111, 1'b1, 11'h020, 32'h22222222, 1'b0, 11'h000, 32'h0, 3'd1, 3'd1, 1'b1};
        vt[1] = '{1'b0, 11'h000, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 11'h010, 32'h11111111, 3'd0, 3'd1, 1'b1};
        vt[2] = '{1'b0, 11'h000, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 11'h020, 32'h22222222, 3'd0, 3'd0, 1'b1};
        vt[3] = '{1'b1, 11'h005, 32'hDEADBEEF, 1'b0, 11'h000, 32'h0, 1'b0, 11'h020, 32'h22222222, 3'd1, 3'd0, 1'b1};
        vt[4] = '{1'b0, 11'h000, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 11'h005, 32'hDEADBEEF, 3'd0, 3'd0, 1'b1};
        vt[5] = '{1'b0, 11'h000, 32'h0, 1'b0, 11'h000, 32'h0, 1'b0, 11'h005, 32'hDEADBEEF, 3'd0, 3'd0, 1'b0};
        vt[6] = '{1'b1, 11'h040, 32'h44444444, 1'b1, 11'h030, 32'h33333333, 1'b0, 11'h005, 32'hDEADBEEF, 3'd1, 3'd1, 1'b1};
`ifdef WB_FIXED_PRIO_EN
        vt[7] = '{1'b0, 11'h000, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 11'h040, 32'h44444444, 3'd0, 3'd1, 1'b1};
        vt[8] = '{1'b0, 11'h000, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 11'h030, 32'h33333333, 3'd0, 3'd0, 1'b1};
`else
        vt[7] = '{1'b0, 11'h000, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 11'h030, 32'h33333333, 3'd1, 3'd0, 1'b1};
        vt[8] = '{1'b0, 11'h000, 32'h0, 1'b0, 11'h000, 32'h0, 1'b1, 11'h040, 32'h44444444, 3'd0, 3'd0, 1'b1};
`endif

        @(negedge clk);
        do_reset();

        // Directed vectors: tie after reset, single write latency, tie with lane 1 granted last.
        for (int i = 0; i < 9; i++) begin
            step(vt[i].v1, vt[i].a1, vt[i].d1, vt[i].v2, vt[i].a2, vt[i].d2);
            chk($sformatf("vec%0d_w_en", i), 64'(w_en), 64'(vt[i].wen));
            chk($sformatf("vec%0d_w_adrs", i), 64'(w_adrs), 64'(vt[i].wa));
            chk($sformatf("vec%0d_data_in", i), 64'(data_in), 64'(vt[i].wd));
            chk($sformatf("vec%0d_counts", i), 64'({l1_count, l2_count}), 64'({vt[i].c1, vt[i].c2}));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vt[i].bsy));
        end

        // Both lanes streaming: FIFOs fill, ready drops at full, writes every cycle.
        do_reset();
        wen_run = 0; max_c1 = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 11'(12'h100 + i), 32'(32'hA000 + i), 1'b1, 11'(12'h200 + i), 32'(32'hB000 + i));
            if (i >= 2) wen_run += int'(w_en);
            if (int'(l1_count) > max_c1) max_c1 = int'(l1_count);
        end
`ifndef WB_FIXED_PRIO_EN
        chk("stream_every_cycle", 64'(wen_run), 64'(22));
        chk("stream_l1_peak_full", 64'(max_c1), 64'(DEPTH));
`endif
        repeat (12) idle();
        chk("stream_drained", 64'({l1_count, l2_count, busy}), 64'(0));

        // Reset asserted mid-stream with entries queued: no write after release.
        step(1'b1, 11'h300, 32'hC0, 1'b1, 11'h301, 32'hC1);
        step(1'b1, 11'h302, 32'hC2, 1'b0, 11'h0, 32'h0);
        step(1'b1, 11'h303, 32'hC3, 1'b0, 11'h0, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_w_en", 64'(w_en), 64'(0));
        chk("midrst_counts", 64'({l1_count, l2_count}), 64'(0));
        model_reset();
        l1_valid = 1'b0; l2_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 60), 11'($urandom), $urandom,
                 ($urandom_range(0, 99) < 60), 11'($urandom), $urandom);
        end
        repeat (12) idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
